// File: rtl/seq_detect_param_pkg.sv
// Shared defaults and helpers for the parametrised serial sequence detector.
package seq_det_pkg;

  localparam int PAT_W_DEF = 6;
  localparam int CNT_W_DEF = 8;
  localparam int LEN_DEF   = 6;
  localparam logic [PAT_W_DEF-1:0] PAT_DEF = 6'b101101;

  // Widest mask len_mask can build; callers size-cast down to their PAT_W.
  localparam int MASK_W = 32;

  // Width needed to hold a length in the range 0..pat_w.
  function automatic int lw_of(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

  // Mask with the low 'len' bits set; bits at and above 'len' are zero.
  function automatic logic [MASK_W-1:0] len_mask(input int unsigned len);
    logic [MASK_W-1:0] m;
    m = '0;
    for (int i = 0; i < MASK_W; i++) begin
      if (i < len) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/seq_detect_param_if.sv
// Bit-stream, configuration and result signals of the sequence detector.
// The master side drives the stream and configuration; the slave is the detector.
interface seq_detect_param_if
  import seq_det_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int LW    = lw_of(PAT_W)
);

  logic             en_i;
  logic             in_i;
  logic             cfg_load_i;
  logic [PAT_W-1:0] pat_i;
  logic [LW-1:0]    pat_len_i;
  logic             overlap_i;
  logic             out_o;
  logic             out_q_o;
  logic [CNT_W-1:0] match_cnt_o;
  logic             cnt_sat_o;

  modport master (
    output en_i, in_i, cfg_load_i, pat_i, pat_len_i, overlap_i,
    input  out_o, out_q_o, match_cnt_o, cnt_sat_o
  );

  modport slave (
    input  en_i, in_i, cfg_load_i, pat_i, pat_len_i, overlap_i,
    output out_o, out_q_o, match_cnt_o, cnt_sat_o
  );

endinterface

// File: rtl/seq_detect_param_cmp.sv
// Combinational window comparator: the low len_i bits of the window must equal
// the low len_i bits of the pattern. A zero length never matches.
module seq_match_cmp
  import seq_det_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int LW    = lw_of(PAT_W)
) (
  input  logic [PAT_W-1:0] window_i,
  input  logic [PAT_W-1:0] pat_i,
  input  logic [LW-1:0]    len_i,
  output logic             match_o
);

  logic [PAT_W-1:0] mask;

  // Mask off the bits above the active length, then compare what remains.
  // NOTE: every signal assigned in always_comb gets a value on every path
  // (here unconditionally) so no latch is inferred.
  always_comb begin
    mask    = PAT_W'(len_mask(32'(len_i)));
    match_o = (len_i != '0) && (((window_i ^ pat_i) & mask) == '0);
  end

endmodule

// File: rtl/seq_detect_param.sv
// Parametrised serial sequence detector.
// State is (hist, fill): the most recent valid bits and how many of them are
// fresh since the last clear. A match needs len-1 fresh history bits plus the
// incoming bit, so out is a same-cycle (Mealy) decode of the arriving bit.
// out_q is out delayed one edge; match_cnt counts detects and saturates.
module seq_detect_param
  import seq_det_pkg::*;
#(
  parameter int               PAT_W   = PAT_W_DEF,
  parameter int               CNT_W   = CNT_W_DEF,
  parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(PAT_DEF),
  parameter int               LEN_RST = LEN_DEF
) (
  input logic              clk,
  input logic              rst,
  seq_detect_param_if.slave bus
);

  localparam int            LW        = lw_of(PAT_W);
  localparam logic [LW-1:0] PAT_W_L   = LW'(PAT_W);
  localparam logic [LW-1:0] LEN_RST_L = LW'(LEN_RST);

  // Configuration captured on cfg_load.
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LW-1:0]    len_q, len_d;
  logic             ovl_q, ovl_d;

  // Only PAT_W-1 history bits are kept: together with the incoming bit they
  // form the full PAT_W-bit comparison window. An older bit is never compared.
  logic [PAT_W-2:0] hist_q, hist_d;
  logic [LW-1:0]    fill_q, fill_d;

  logic             det_q, det_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [PAT_W-1:0] window;
  logic [LW-1:0]    len_cap;
  logic             pat_hit;
  logic             fill_ok;
  logic             cnt_sat;
  logic             det;

  assign window = {hist_q, bus.in_i};

  // Lengths above PAT_W are clamped when captured so len_q is always 0..PAT_W.
  assign len_cap = (bus.pat_len_i > PAT_W_L) ? PAT_W_L : bus.pat_len_i;

  seq_match_cmp #(
    .PAT_W (PAT_W),
    .LW    (LW)
  ) u_cmp (
    .window_i (window),
    .pat_i    (pat_q),
    .len_i    (len_q),
    .match_o  (pat_hit)
  );

  // Enough fresh history for the incoming bit to complete a pattern:
  // fill >= len-1, written as fill+1 >= len to stay unsigned.
  assign fill_ok = ({1'b0, fill_q} + 1'b1) >= {1'b0, len_q};

  assign cnt_sat = &cnt_q;

  // cfg_load takes priority over a valid bit, and that bit is dropped.
  assign det = bus.en_i & ~bus.cfg_load_i & fill_ok & pat_hit;

  // Next-state decode for configuration, history, fill, delayed detect and counter.
  always_comb begin
    pat_d  = pat_q;
    len_d  = len_q;
    ovl_d  = ovl_q;
    hist_d = hist_q;
    fill_d = fill_q;
    cnt_d  = cnt_q;
    det_d  = det;

    if (bus.cfg_load_i) begin
      pat_d  = bus.pat_i;
      len_d  = len_cap;
      ovl_d  = bus.overlap_i;
      hist_d = '0;
      fill_d = '0;
    end else if (bus.en_i) begin
      hist_d = window[PAT_W-2:0];
      if (det && !ovl_q) begin
        // Non-overlapping: the next match has to be built from fresh bits.
        fill_d = '0;
      end else if (fill_q != PAT_W_L) begin
        fill_d = fill_q + 1'b1;
      end
    end

    if (det && !cnt_sat) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers; reset restores the default pattern and clears all progress.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its next value from the same pre-edge snapshot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_q  <= PAT_RST;
      len_q  <= LEN_RST_L;
      ovl_q  <= 1'b1;
      hist_q <= '0;
      fill_q <= '0;
      det_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      pat_q  <= pat_d;
      len_q  <= len_d;
      ovl_q  <= ovl_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      det_q  <= det_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.out_o       = det;
  assign bus.out_q_o     = det_q;
  assign bus.match_cnt_o = cnt_q;
  assign bus.cnt_sat_o   = cnt_sat;

endmodule
